// File: rtl/alu_pkg.sv
// Shared definitions for the ALU requester: mode encodings, legality helper
// and the requester state enum.
package alu_pkg;

  localparam logic [3:0] ADD      = 4'd0;
  localparam logic [3:0] SUB      = 4'd1;
  localparam logic [3:0] AND      = 4'd2;
  localparam logic [3:0] OR       = 4'd3;
  localparam logic [3:0] XOR      = 4'd4;
  localparam logic [3:0] EQ       = 4'd5;
  localparam logic [3:0] GE       = 4'd6;
  localparam logic [3:0] SRL      = 4'd7;
  localparam logic [3:0] SLL      = 4'd8;
  localparam logic [3:0] MUL      = 4'd9;
  localparam logic [3:0] DIV      = 4'd10;
  localparam logic [3:0] MODE_MAX = DIV;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} alu_req_state_t;

  // Modes above MODE_MAX hang the ALU, so they must never reach it.
  function automatic logic mode_legal(input logic [3:0] mode);
    return mode <= MODE_MAX;
  endfunction

endpackage

// File: rtl/alu_req_stats.sv
// Saturating operation/error counters for the ALU requester response channel.
// Only instantiated when ALU_REQ_STATS_EN is defined.
module alu_req_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsp_fire,
  input  logic        rsp_err,
  output logic [31:0] stat_ops,
  output logic [15:0] stat_errs
);

  logic [31:0] ops_q, ops_d;
  logic [15:0] errs_q, errs_d;

  always_comb begin
    ops_d  = ops_q;
    errs_d = errs_q;
    if (rsp_fire) begin
      if (ops_q != '1) ops_d = ops_q + 32'd1;
      if (rsp_err && errs_q != '1) errs_d = errs_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q  <= '0;
      errs_q <= '0;
    end else begin
      ops_q  <= ops_d;
      errs_q <= errs_d;
    end
  end

  assign stat_ops  = ops_q;
  assign stat_errs = errs_q;

endmodule

// File: rtl/alu_requester.sv
// Initiator-side driver for the multi-cycle ALU: one command in flight, timeout
// guard, illegal-mode filter. Define ALU_REQ_STATS_EN to add stat_ops/stat_errs.
module alu_requester
  import alu_pkg::*;
#(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 63,
  parameter int CNT_W          = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_valid,
  output logic [31:0]      alu_in_A,
  output logic [31:0]      alu_in_B,
  output logic [3:0]       alu_mode,
  input  logic             alu_ready,
  input  logic [63:0]      alu_out_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
`ifdef ALU_REQ_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [15:0]      stat_errs
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  alu_req_state_t   state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [3:0]       mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its peers; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every _d gets a hold default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid && cmd_ready) begin
          tag_d = cmd_tag;
          if (mode_legal(cmd_mode)) begin
            a_d     = cmd_a;
            b_d     = cmd_b;
            mode_d  = cmd_mode;
            state_d = ISSUE;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready pulse landing on the final budget cycle still counts.
        if (alu_ready) begin
          data_d  = alu_out_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_d == TIMEOUT_LIM) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    alu_valid = (state_q == ISSUE);
    rsp_valid = (state_q == RESP);
  end

  assign alu_in_A = a_q;
  assign alu_in_B = b_q;
  assign alu_mode = mode_q;
  assign rsp_data = data_q;
  assign rsp_tag  = tag_q;
  assign rsp_err  = err_q;

`ifdef ALU_REQ_STATS_EN
  alu_req_stats u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsp_fire  (rsp_valid && rsp_ready),
    .rsp_err   (err_q),
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs)
  );
`endif

endmodule

// File: tb/tb_alu_requester.sv
// Directed bench for alu_requester with a behavioural ALU stub whose latency
// can be overridden or disabled to exercise the timeout path.
module tb_alu_requester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_mode = '0;
  logic [3:0]  cmd_tag = '0;
  logic        alu_valid;
  logic [31:0] alu_in_A, alu_in_B;
  logic [3:0]  alu_mode;
  logic        alu_ready;
  logic [63:0] alu_out_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
`ifdef ALU_REQ_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  alu_requester dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_mode     (cmd_mode),
    .cmd_tag      (cmd_tag),
    .alu_valid    (alu_valid),
    .alu_in_A     (alu_in_A),
    .alu_in_B     (alu_in_B),
    .alu_mode     (alu_mode),
    .alu_ready    (alu_ready),
    .alu_out_data (alu_out_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .rsp_err      (rsp_err)
`ifdef ALU_REQ_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_errs    (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int err_cnt  = 0;
  int alu_valid_cnt = 0;

  // ---------------- behavioural ALU stub ----------------
  bit          stub_en = 1'b1;
  int          lat_override = 0;
  logic        force_ready = 1'b0;
  logic        model_ready;
  logic [63:0] model_data;
  logic [7:0]  cd;

  function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] m);
    logic [31:0] r;
    case (m)
      4'd0: begin
        r = a + b;
        if (a[31] == b[31] && r[31] != a[31]) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {32'h0, r};
      end
      4'd1:  return {32'h0, a - b};
      4'd2:  return {32'h0, a & b};
      4'd3:  return {32'h0, a | b};
      4'd4:  return {32'h0, a ^ b};
      4'd5:  return {63'h0, a == b};
      4'd6:  return {63'h0, a >= b};
      4'd7:  return {32'h0, a >> b[4:0]};
      4'd8:  return {32'h0, a << b[4:0]};
      4'd9:  return {32'h0, a} * {32'h0, b};
      4'd10: return (b == 0) ? '1 : {a % b, a / b};
      default: return '0;
    endcase
  endfunction

  function automatic int stub_lat(input logic [3:0] m);
    if (lat_override != 0) return lat_override;
    return (m >= 4'd9) ? 33 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd          <= '0;
      model_ready <= 1'b0;
      model_data  <= '0;
    end else begin
      model_ready <= 1'b0;
      if (alu_valid && stub_en) begin
        model_data <= alu_ref(alu_in_A, alu_in_B, alu_mode);
        if (stub_lat(alu_mode) == 1) model_ready <= 1'b1;
        else cd <= 8'(stub_lat(alu_mode) - 1);
      end else if (cd != 0) begin
        cd          <= cd - 8'd1;
        model_ready <= (cd == 8'd1);
      end
    end
  end

  assign alu_ready    = model_ready | force_ready;
  assign alu_out_data = force_ready ? 64'hDEAD_BEEF_0BAD_F00D : model_data;

  always @(posedge clk) if (rst_n && alu_valid) alu_valid_cnt++;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mode;
    logic [3:0]  tag;
    logic [63:0] data;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  // Issue one command, measure accept-to-rsp_valid latency, check response,
  // optionally hold off rsp_ready, then complete the handshake.
  task automatic run_vec(input vec_t v, input string nm);
    int k;
    bit stable;
    bit legal;
    legal = (v.mode <= 4'd10);
    k = 0;
    while (!cmd_ready && k < 100) begin step(); k++; end
    check({nm, "_cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    alu_valid_cnt = 0;
    cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_mode = v.mode; cmd_tag = v.tag;
    step();
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_mode = '0; cmd_tag = '0;
    k = 1;
    stable = 1'b1;
    while (!rsp_valid && k < 100) begin
      if (cmd_ready !== 1'b0) stable = 1'b0;
      if (legal && (alu_in_A !== v.a || alu_in_B !== v.b || alu_mode !== v.mode)) stable = 1'b0;
      step();
      k++;
    end
    check({nm, "_latency"}, 64'(k), 64'(v.lat));
    check({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({nm, "_rsp_data"}, rsp_data, v.data);
    check({nm, "_rsp_tag"}, 64'(rsp_tag), 64'(v.tag));
    check({nm, "_rsp_err"}, 64'(rsp_err), 64'(v.err));
    check({nm, "_alu_valid_pulses"}, 64'(alu_valid_cnt), legal ? 64'd1 : 64'd0);
    check({nm, "_inflight_stable"}, 64'(stable), 64'd1);
    if (v.hold > 0) begin
      stable = 1'b1;
      repeat (v.hold) begin
        step();
        if (rsp_valid !== 1'b1 || rsp_data !== v.data || rsp_tag !== v.tag ||
            rsp_err !== v.err || cmd_ready !== 1'b0) stable = 1'b0;
      end
      check({nm, "_backpressure_stable"}, 64'(stable), 64'd1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    hs_cnt++;
    if (v.err) err_cnt++;
    check({nm, "_post_hs_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({nm, "_post_hs_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // Watches for a spurious extra response over a few idle cycles.
  task automatic check_quiet(input string nm);
    bit quiet;
    quiet = 1'b1;
    repeat (5) begin
      step();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
    end
    check({nm, "_no_extra_rsp"}, 64'(quiet), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'd5,          32'd7,      4'd0,  4'd3,  64'd12,                 1'b0, 3,  2};
    vecs[1]  = '{32'h7FFF_FFFF,  32'd1,      4'd0,  4'd1,  64'h7FFF_FFFF,          1'b0, 3,  0};
    vecs[2]  = '{32'd3,          32'd5,      4'd9,  4'd2,  64'd15,                 1'b0, 35, 3};
    vecs[3]  = '{32'd9,          32'd4,      4'd1,  4'd4,  64'd5,                  1'b0, 3,  0};
    vecs[4]  = '{32'hF0F0,       32'hFF00,   4'd2,  4'd5,  64'hF000,               1'b0, 3,  0};
    vecs[5]  = '{32'hF0F0,       32'hFF00,   4'd3,  4'd6,  64'hFFF0,               1'b0, 3,  0};
    vecs[6]  = '{32'hF0F0,       32'hFF00,   4'd4,  4'd7,  64'h0FF0,               1'b0, 3,  0};
    vecs[7]  = '{32'd6,          32'd6,      4'd5,  4'd8,  64'd1,                  1'b0, 3,  0};
    vecs[8]  = '{32'd3,          32'd8,      4'd6,  4'd9,  64'd0,                  1'b0, 3,  0};
    vecs[9]  = '{32'h80,         32'd3,      4'd7,  4'd10, 64'h10,                 1'b0, 3,  0};
    vecs[10] = '{32'd1,          32'd31,     4'd8,  4'd11, 64'h8000_0000,          1'b0, 3,  0};
    vecs[11] = '{32'hFFFF_FFFF,  32'd2,      4'd9,  4'd12, 64'h1_FFFF_FFFE,        1'b0, 35, 0};
    vecs[12] = '{32'd17,         32'd5,      4'd10, 4'd13, 64'h0000_0002_0000_0003, 1'b0, 35, 0};
    vecs[13] = '{32'd1,          32'd2,      4'hB,  4'd14, 64'd0,                  1'b1, 1,  10};
    vecs[14] = '{32'd1,          32'd2,      4'hF,  4'd15, 64'd0,                  1'b1, 1,  0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_alu_outputs", {27'h0, alu_valid, alu_in_A | alu_in_B, alu_mode}, 64'd0);
    check("reset_rsp_outputs", {59'h0, rsp_valid, rsp_err, rsp_tag} | rsp_data, 64'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout: the stub never answers, so the full 63-cycle WAIT budget runs out.
    stub_en = 1'b0;
    run_vec('{32'd1, 32'd2, 4'd0, 4'd7, 64'd0, 1'b1, 65, 0}, "timeout");
    stub_en = 1'b1;
    force_ready = 1'b1;
    step();
    force_ready = 1'b0;
    check_quiet("late_pulse_idle");

    // Ready on the last budget cycle wins; one cycle later is a timeout.
    lat_override = 63;
    run_vec('{32'd2, 32'd3, 4'd0, 4'd6, 64'd5, 1'b0, 65, 0}, "ready_at_limit");
    lat_override = 64;
    run_vec('{32'd2, 32'd3, 4'd0, 4'd5, 64'd0, 1'b1, 65, 0}, "ready_past_limit");
    lat_override = 0;
    check_quiet("late_pulse_resp");

    // Asynchronous reset in the middle of a multiply.
    cmd_valid = 1'b1; cmd_a = 32'd11; cmd_b = 32'd13; cmd_mode = 4'd9; cmd_tag = 4'd9;
    step();
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_mode = '0; cmd_tag = '0;
    repeat (10) step();
    check("mid_wait_busy", {62'h0, cmd_ready, rsp_valid}, 64'd0);
    check("mid_wait_alu_in_A", {32'h0, alu_in_A}, 64'd11);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_alu_valid", 64'(alu_valid), 64'd0);
    check("rst_async_alu_in", {alu_in_A, alu_in_B}, 64'd0);
    check("rst_async_alu_mode", 64'(alu_mode), 64'd0);
    check("rst_async_rsp_ctrl", {58'h0, rsp_valid, rsp_err, rsp_tag}, 64'd0);
    check("rst_async_rsp_data", rsp_data, 64'd0);
    hs_cnt = 0;
    err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    run_vec('{32'd20, 32'd22, 4'd0, 4'd1, 64'd42, 1'b0, 3, 0}, "post_reset_add");
    check_quiet("post_reset");

`ifdef ALU_REQ_STATS_EN
    check("stat_ops", {32'h0, stat_ops}, 64'(hs_cnt));
    check("stat_errs", {48'h0, stat_errs}, 64'(err_cnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
